// File: rtl/game_timer_ctrl.sv
// Game timer controller: start/pause/resume FSM, tick prescaler, saturating countdown with bonus time.
// Optional low-time blink indicator is built only when GAME_TIMER_WARN_EN is defined.
module game_timer_ctrl #(
    parameter int unsigned TIME_W       = 8,
    parameter int unsigned INIT_TIME    = 60,
    parameter int unsigned MAX_TIME     = 99,
    parameter int unsigned CLK_PER_TICK = 50,
    parameter int unsigned WARN_TIME    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startN,
    input  logic              pause_req,
    input  logic              add_time,
    input  logic [TIME_W-1:0] add_val,
    output logic [TIME_W-1:0] time_left,
    output logic              tick,
    output logic              running,
    output logic              paused,
    output logic              end_count,
    output logic              warn
);

    localparam int unsigned PRE_W = $clog2(CLK_PER_TICK);
    localparam int unsigned SUM_W = TIME_W + 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_PER_TICK - 1);
    localparam logic [TIME_W-1:0] INIT_VAL = TIME_W'(INIT_TIME);
    localparam logic [TIME_W-1:0] MAX_VAL  = TIME_W'(MAX_TIME);
    localparam logic [SUM_W-1:0]  MAX_SUM  = SUM_W'(MAX_TIME);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OFF} stateT;

    stateT             state, stateNext;
    logic [PRE_W-1:0]  prescaler, preNext;
    logic [TIME_W-1:0] timeNext;
    logic [SUM_W-1:0]  sum;
    logic              tickNext;

    // Next-state, prescaler and countdown arithmetic
    always_comb begin
        stateNext = state;
        preNext   = prescaler;
        timeNext  = time_left;
        tickNext  = 1'b0;
        sum       = '0;
        case (state)
            IDLE, OFF: begin
                if (!startN) begin
                    timeNext  = INIT_VAL;
                    preNext   = '0;
                    stateNext = (INIT_TIME == 0) ? OFF : RUN;
                end
            end
            RUN: begin
                if (pause_req) begin
                    stateNext = PAUSE;
                end else if (prescaler == PRE_LAST) begin
                    preNext  = '0;
                    tickNext = 1'b1;
                end else begin
                    preNext = prescaler + PRE_W'(1);
                end
            end
            PAUSE: begin
                if (pause_req) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Decrement and bonus are combined one bit wider, then clamped to the ceiling
        if (state == RUN || state == PAUSE) begin
            sum = {1'b0, time_left} - SUM_W'(tickNext)
                + (add_time ? {1'b0, add_val} : SUM_W'(0));
            timeNext = (sum > MAX_SUM) ? MAX_VAL : sum[TIME_W-1:0];
            if (tickNext && timeNext == '0) begin
                stateNext = OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            time_left <= '0;
            tick      <= 1'b0;
            running   <= 1'b0;
            paused    <= 1'b0;
            end_count <= 1'b0;
        end else begin
            state     <= stateNext;
            prescaler <= preNext;
            time_left <= timeNext;
            tick      <= tickNext;
            running   <= (stateNext == RUN);
            paused    <= (stateNext == PAUSE);
            end_count <= (stateNext == OFF);
        end
    end

`ifdef GAME_TIMER_WARN_EN
    localparam logic [TIME_W-1:0] WARN_VAL = TIME_W'(WARN_TIME);

    logic warnNext, inWinNow, inWinNext;

    // Blink inside the low-time window: set on entry, toggle per tick, hold while paused
    always_comb begin
        inWinNow  = (time_left != '0) && (time_left <= WARN_VAL);
        inWinNext = ((stateNext == RUN) || (stateNext == PAUSE))
                  && (timeNext != '0) && (timeNext <= WARN_VAL);
        warnNext  = 1'b0;
        if (inWinNext) begin
            if (!inWinNow) begin
                warnNext = 1'b1;
            end else if (tickNext) begin
                warnNext = ~warn;
            end else begin
                warnNext = warn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warn <= 1'b0;
        end else begin
            warn <= warnNext;
        end
    end
`else
    // Indicator absent in this build; the threshold parameter has no effect
    assign warn = 1'b0 && (WARN_TIME != 0);
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: directed vector table, hand sequences and a randomized run
// checked against a cycle-level behavioural model of the timer rules.
module tb_game_timer_ctrl;

    localparam int unsigned TIME_W = 8;
    localparam int INIT  = 3;
    localparam int MAXT  = 5;
    localparam int CPT   = 4;
    localparam int WARNT = 2;
`ifdef GAME_TIMER_WARN_EN
    localparam bit WARN_BUILD = 1'b1;
`else
    localparam bit WARN_BUILD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              startN = 1'b1;
    logic              pause_req = 1'b0;
    logic              add_time = 1'b0;
    logic [TIME_W-1:0] add_val = '0;
    logic [TIME_W-1:0] time_left;
    logic              tick, running, paused, end_count, warn;

    int checks = 0;
    int failures = 0;

    game_timer_ctrl #(
        .TIME_W(TIME_W), .INIT_TIME(INIT), .MAX_TIME(MAXT),
        .CLK_PER_TICK(CPT), .WARN_TIME(WARNT)
    ) dut (
        .clk(clk), .reset(reset), .startN(startN), .pause_req(pause_req),
        .add_time(add_time), .add_val(add_val), .time_left(time_left),
        .tick(tick), .running(running), .paused(paused),
        .end_count(end_count), .warn(warn)
    );

    always #5 clk = ~clk;

    // Behavioural model: game in progress / frozen / over, cycles elapsed in current tick
    bit mActive, mFrozen, mOver, mTick, mWarn;
    int mRem, mCyc;

    task automatic modelStep(input bit rst, input bit sN, input bit pr, input bit at, input int av);
        int nextRem;
        bit dec, prevWin, win;
        prevWin = mActive && mRem > 0 && mRem <= WARNT;
        mTick = 1'b0;
        dec = 1'b0;
        if (rst) begin
            mActive = 0; mFrozen = 0; mOver = 0; mRem = 0; mCyc = 0;
        end else if (!mActive) begin
            if (!sN) begin
                mRem = INIT; mCyc = 0; mFrozen = 0;
                mOver = (INIT == 0);
                mActive = !mOver;
            end
        end else begin
            if (mFrozen) begin
                if (pr) mFrozen = 0;
            end else if (pr) begin
                mFrozen = 1;
            end else begin
                mCyc++;
                if (mCyc == CPT) begin
                    mCyc = 0; dec = 1; mTick = 1;
                end
            end
            nextRem = mRem - int'(dec) + (at ? av : 0);
            if (nextRem > MAXT) nextRem = MAXT;
            mRem = nextRem;
            if (mRem == 0) begin
                mActive = 0; mOver = 1; mFrozen = 0;
            end
        end
        win = mActive && mRem > 0 && mRem <= WARNT;
        if (!win || rst) mWarn = 0;
        else if (!prevWin) mWarn = 1;
        else if (mTick) mWarn = !mWarn;
    endtask

    task automatic step(input bit rst, input bit sN, input bit pr, input bit at, input int av);
        reset = rst; startN = sN; pause_req = pr; add_time = at; add_val = TIME_W'(av);
        @(posedge clk);
        #1;
        modelStep(rst, sN, pr, at, av);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit rst, sN, pr, at;
        int av;
        int tl;
        bit tk, run, pau, en, wW;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(bit rst, bit sN, bit pr, bit at, int av,
                               int tl, bit tk, bit run, bit pau, bit en, bit wW);
        vecT v;
        v.rst = rst; v.sN = sN; v.pr = pr; v.at = at; v.av = av;
        v.tl = tl; v.tk = tk; v.run = run; v.pau = pau; v.en = en; v.wW = wW;
        return v;
    endfunction

    task automatic pushRun(int n, int tl, bit wW);
        for (int i = 0; i < n; i++) vecs.push_back(mk(0,1,0,0,0, tl,0,1,0,0,wW));
    endtask

    initial begin
        // Directed table: inputs for one edge, outputs expected just after it
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));   // reset
        vecs.push_back(mk(0,1,0,1,4, 0,0,0,0,0,0));   // bonus in IDLE ignored
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,0,0,0));   // pause in IDLE ignored
        vecs.push_back(mk(0,0,0,0,0, 3,0,1,0,0,0));   // start
        vecs.push_back(mk(0,0,0,0,0, 3,0,1,0,0,0));   // startN ignored in RUN
        pushRun(2, 3, 0);
        vecs.push_back(mk(0,1,0,0,0, 2,1,1,0,0,1));   // first tick, 4th RUN edge
        pushRun(3, 2, 1);
        vecs.push_back(mk(0,1,0,0,0, 1,1,1,0,0,0));
        pushRun(3, 1, 0);
        vecs.push_back(mk(0,1,0,0,0, 0,1,0,0,1,0));   // expire
        vecs.push_back(mk(0,1,1,1,3, 0,0,0,0,1,0));   // pause/bonus ignored in OFF
        vecs.push_back(mk(0,0,0,0,0, 3,0,1,0,0,0));   // restart
        vecs.push_back(mk(0,1,0,1,4, 5,0,1,0,0,0));   // saturate at MAX
        vecs.push_back(mk(0,1,1,0,0, 5,0,0,1,0,0));   // pause
        vecs.push_back(mk(0,0,0,0,0, 5,0,0,1,0,0));   // startN ignored in PAUSE
        vecs.push_back(mk(0,1,0,1,0, 5,0,0,1,0,0));   // zero bonus
        vecs.push_back(mk(0,1,1,0,0, 5,0,1,0,0,0));   // resume
        pushRun(2, 5, 0);
        vecs.push_back(mk(0,1,0,0,0, 4,1,1,0,0,0));
        pushRun(3, 4, 0);
        vecs.push_back(mk(0,1,1,0,0, 4,0,0,1,0,0));   // pause beats terminal count
        vecs.push_back(mk(0,1,1,0,0, 4,0,1,0,0,0));
        vecs.push_back(mk(0,1,0,0,0, 3,1,1,0,0,0));
        pushRun(3, 3, 0);
        vecs.push_back(mk(0,1,0,0,0, 2,1,1,0,0,1));
        pushRun(3, 2, 1);
        vecs.push_back(mk(0,1,0,0,0, 1,1,1,0,0,0));
        pushRun(3, 1, 0);
        vecs.push_back(mk(0,1,0,1,2, 2,1,1,0,0,1));   // tick 1->0 plus bonus 2
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,0,0,0));   // reset mid-RUN
        vecs.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0));

        #2;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].sN, vecs[i].pr, vecs[i].at, vecs[i].av);
            chk($sformatf("vec%0d.time_left", i), int'(time_left), vecs[i].tl);
            chk($sformatf("vec%0d.tick", i), int'(tick), int'(vecs[i].tk));
            chk($sformatf("vec%0d.running", i), int'(running), int'(vecs[i].run));
            chk($sformatf("vec%0d.paused", i), int'(paused), int'(vecs[i].pau));
            chk($sformatf("vec%0d.end_count", i), int'(end_count), int'(vecs[i].en));
            chk($sformatf("vec%0d.warn", i), int'(warn), int'(vecs[i].wW & WARN_BUILD));
        end

        // Pause on the third RUN cycle, hold, resume: tick two edges later
        step(1,1,0,0,0);
        step(0,0,0,0,0);
        step(0,1,0,0,0);
        step(0,1,0,0,0);
        step(0,1,1,0,0);
        chk("pause.paused", int'(paused), 1);
        for (int i = 0; i < 10; i++) begin
            step(0,1,0,0,0);
            chk("pause.hold_tick", int'(tick), 0);
            chk("pause.hold_tl", int'(time_left), 3);
        end
        step(0,1,1,0,0);
        chk("resume.running", int'(running), 1);
        step(0,1,0,0,0);
        chk("resume.early_tick", int'(tick), 0);
        step(0,1,0,0,0);
        chk("resume.tick", int'(tick), 1);
        chk("resume.time_left", int'(time_left), 2);

        // Randomized run against the model
        step(1,1,0,0,0);
        for (int c = 0; c < 3000; c++) begin
            bit rst, sN, pr, at;
            int av;
            rst = ($urandom_range(0, 199) == 0);
            sN  = ($urandom_range(0, 5) != 0);
            pr  = ($urandom_range(0, 11) == 0);
            at  = ($urandom_range(0, 7) == 0);
            av  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 3));
            step(rst, sN, pr, at, av);
            chk("rnd.time_left", int'(time_left), mRem);
            chk("rnd.tick", int'(tick), int'(mTick));
            chk("rnd.running", int'(running), int'(mActive && !mFrozen));
            chk("rnd.paused", int'(paused), int'(mActive && mFrozen));
            chk("rnd.end_count", int'(end_count), int'(mOver));
            chk("rnd.warn", int'(warn), int'(mWarn & WARN_BUILD));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
